// File: rtl/mxv_op_sequencer.sv
// +----------------------------------------------------------------------------+
// | mxv_op_sequencer                                                           |
// | Row-by-row matrix x vector sequencer: reads rows from the matrix RAMs,     |
// | multiply-accumulates against a latched vector and hands out row results.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module mxv_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 8,
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [3:0]                 mat_size,
  input  logic [MAX_N*DATA_W-1:0]    vec_data,
  output logic                       rd_en,
  output logic [$clog2(MAX_N)-1:0]   rd_row,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       res_valid,
  output logic [ACC_W-1:0]           res_data,
  input  logic                       res_ready,
  output logic                       busy,
  output logic                       op_done,
  output logic                       size_err
);

  localparam int              ROW_W      = $clog2(MAX_N);
  localparam logic [3:0]      c_MAX_SIZE = 4'(MAX_N);
  localparam logic [ROW_W-1:0] c_ONE     = ROW_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_PUSH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    r_state;
  logic [3:0]                r_n;
  logic [MAX_N*DATA_W-1:0]   r_vec;
  logic [ROW_W-1:0]          r_row;
  logic [ROW_W-1:0]          r_col;
  logic                      r_pend;
  logic [ROW_W-1:0]          r_pcol;
  logic [ACC_W-1:0]          r_acc;

  logic [DATA_W-1:0]         w_vec_elem [MAX_N];
  logic [DATA_W-1:0]         w_vsel;
  logic [2*DATA_W-1:0]       w_prod;
  logic [ACC_W-1:0]          w_acc_next;
  logic                      w_size_ok;
  logic                      w_last_col;
  logic                      w_last_row;
  logic [ROW_W-1:0]          w_col_inc;
  logic [ROW_W-1:0]          w_row_inc;

  genvar g;
  generate
    for (g = 0; g < MAX_N; g++) begin : g_vec_elem
      assign w_vec_elem[g] = r_vec[g*DATA_W +: DATA_W];
    end
  endgenerate

  // The product uses the column read one cycle earlier, matching RAM latency.
  assign w_vsel     = w_vec_elem[r_pcol];
  assign w_prod     = {{DATA_W{1'b0}}, rd_data} * {{DATA_W{1'b0}}, w_vsel};
  assign w_acc_next = r_acc + {{(ACC_W-2*DATA_W){1'b0}}, w_prod};

  assign w_size_ok  = (mat_size != 4'd0) && (mat_size <= c_MAX_SIZE);
  assign w_last_col = (4'(r_col) == (r_n - 4'd1));
  assign w_last_row = (4'(r_row) == (r_n - 4'd1));
  assign w_col_inc  = r_col + c_ONE;
  assign w_row_inc  = r_row + c_ONE;

  assign rd_row  = r_row;
  assign rd_addr = ADDR_W'(r_col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_n       <= 4'd0;
      r_vec     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_pend    <= 1'b0;
      r_pcol    <= '0;
      r_acc     <= '0;
      rd_en     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      busy      <= 1'b0;
      op_done   <= 1'b0;
      size_err  <= 1'b0;
    end else begin
      op_done  <= 1'b0;
      size_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_size_ok) begin
              r_n     <= mat_size;
              r_vec   <= vec_data;
              r_row   <= '0;
              r_col   <= '0;
              r_pend  <= 1'b0;
              r_acc   <= '0;
              rd_en   <= 1'b1;
              busy    <= 1'b1;
              r_state <= S_READ;
            end else begin
              size_err <= 1'b1;
            end
          end
        end

        S_READ: begin
          r_pend <= 1'b1;
          r_pcol <= r_col;
          if (r_pend) begin
            r_acc <= w_acc_next;
          end
          if (w_last_col) begin
            rd_en   <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_col <= w_col_inc;
          end
        end

        S_DRAIN: begin
          r_pend    <= 1'b0;
          r_acc     <= w_acc_next;
          res_data  <= w_acc_next;
          res_valid <= 1'b1;
          r_state   <= S_PUSH;
        end

        S_PUSH: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (w_last_row) begin
              op_done <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_row   <= w_row_inc;
              r_col   <= '0;
              r_acc   <= '0;
              rd_en   <= 1'b1;
              r_state <= S_READ;
            end
          end
        end

        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
